uart_rx_sequencer: RTL
======================

# uart_rx_sequencer

Receive-side controller for the board's 9600-baud UART on the 50 MHz clock. It synchronizes the raw serial line, runs the start/data/parity/stop state machine and generates the mid-bit sampling strobes. It checks each frame and queues good bytes in a 4-entry FIFO. A ready/valid interface hands bytes to the consuming logic, with one-cycle error pulses alongside.

## Interface
- CLKS_PER_BIT, default 5208 — clock cycles per bit (50 MHz / 9600); legal range 8..65535.
- PARITY_EN, default 0 — 1: a parity bit follows the data bits.
- PARITY_ODD, default 0 — 0: even parity; 1: odd parity (used only when PARITY_EN=1).
- clk  input  1  system clock, 50 MHz; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Rx  input  1  raw serial line; idle high; asynchronous to clk.
- rx_data  output  8  byte at the FIFO head; valid only while rx_valid=1.
- rx_valid  output  1  FIFO not empty.
- rx_ready  input  1  consumer accepts the head byte when rx_valid && rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low; byte discarded.
- parity_err  output  1  one-cycle pulse: parity mismatch; byte discarded.
- overrun  output  1  one-cycle pulse: good byte arrived with FIFO full; byte dropped.
- busy  output  1  high in every state except IDLE.

## Operation
- Reset values: rx_valid=0, rx_data=0, all error pulses=0, busy=0, FSM=IDLE, FIFO empty, synchronizer stages=1.
- Synchronizer: two flops on Rx, producing rxs. Only rxs is used internally.
- Timing counters:
  - HALF = floor(CLKS_PER_BIT/2).
  - Bit counter is 16 bits wide.
  - Bit index is 3 bits wide and counts 0..7.
- IDLE:
  - A 1→0 transition on rxs (registered previous value was 1) loads the counter and enters START.
  - Low level alone does not start a frame.
- START:
  - Sample after HALF cycles.
  - rxs=0: enter DATA with counter=CLKS_PER_BIT.
  - rxs=1: false start; return to IDLE with no pulses.
- DATA:
  - Sample once every CLKS_PER_BIT cycles; data is LSB first into a shift register.
  - After bit 7, go to PARITY if PARITY_EN=1, else STOP.
- PARITY:
  - Sample one bit.
  - Error condition: XOR(data bits, parity bit) must equal PARITY_ODD. Record a mismatch flag; the flag takes effect at stop.
- STOP: sample one bit.
  - rxs=0: pulse frame_err and enter BREAK. frame_err has priority over parity_err, so only one pulse fires.
  - rxs=1, parity flag set: pulse parity_err and return to IDLE.
  - rxs=1, otherwise: push the byte to the FIFO (or pulse overrun if full) and return to IDLE.
- BREAK: wait for rxs=1, then enter IDLE. No new frame starts while the line is held low.
- FIFO:
  - Depth 4, with 2-bit read and write pointers that wrap 3→0, plus a 3-bit count.
  - Push and pop in the same cycle when full: the push is accepted and count stays 4 (no overrun).
  - Push and pop in the same cycle when empty: cannot occur, since a pop requires rx_valid.
  - rx_data is registered from the head entry; it holds its value while rx_valid=0.
- Reset asserted mid-frame: the FSM returns to IDLE, the FIFO empties, and the partial byte is lost.
  - After reset release, the line must show a fresh 1→0 edge before a frame is accepted.

## Timing
- t0 = the cycle rxs first reads 0. This is 2–3 cycles after the Rx pin falls.
- Sample points:
  - Start bit: t0+HALF.
  - Data bit i: t0+HALF+(i+1)·CLKS_PER_BIT.
  - Parity: t0+HALF+9·CLKS_PER_BIT.
  - Stop: t0+HALF+(9+PARITY_EN)·CLKS_PER_BIT.
- FIFO write occurs on the stop-sample edge. rx_valid and rx_data are updated in the following cycle.
- Error pulses are high for exactly the cycle after the stop sample.
- FSM enters IDLE the cycle after the stop sample, about half a bit before the frame ends, so back-to-back frames are received.
- Pop: rx_valid && rx_ready at edge n. The next entry (or rx_valid=0) is visible at n+1.
- Throughput: one byte per clock on the output side; sustained rate is limited by the line.

## Test plan
Simulation uses CLKS_PER_BIT=16.
- Reset, then frame 0x55 (PARITY_EN=0), rx_ready=1 → rx_valid high for 1 cycle with rx_data=0x55, exactly t0+8+9·16+1; no error pulses.
- Four frames 0x01, 0x02, 0x03, 0x04 with rx_ready=0, then a fifth frame 0xA5 → overrun pulses once. Raising rx_ready then pops 01, 02, 03, 04 on consecutive cycles, then rx_valid=0.
- Frame 0x3C with the stop bit driven 0, line held low for 40 cycles → one frame_err pulse, no push, busy stays high until the line returns high. A following frame 0x3C is received correctly.
- Rx low for 5 cycles, then back high → false start: no pulses, FSM back in IDLE, busy low by t0+9.
- PARITY_EN=1, PARITY_ODD=0:
  - Frame 0x07 with parity bit 1 → accepted.
  - Frame 0x07 with parity bit 0 → parity_err pulse, FIFO unchanged.
- Reset asserted at data bit 4 of frame 0xF0 → all outputs at reset values immediately. After release, with the line idle for 32 cycles and then frame 0x0F, only 0x0F is received.

Source files
------------

// File: rtl/uart_rx_sequencer.sv
// UART receiver: two-flop line synchronizer, mid-bit sampling frame FSM and a 4-deep byte FIFO.
// States: IDLE wait for falling edge | START verify start bit | DATA shift 8 bits | PARITY check | STOP check | BREAK wait for line high
module uart_rx_sequencer #(
    parameter int CLKS_PER_BIT = 5208,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [15:0] BIT_LEN = 16'(CLKS_PER_BIT);
    localparam logic [15:0] HALF    = 16'(CLKS_PER_BIT / 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t      state, state_next;
    logic        sync1, rxs, rxs_prev;
    logic [15:0] cnt, cnt_next;
    logic [2:0]  bit_idx, idx_next;
    logic [7:0]  shift, shift_next;
    logic        par_bad, par_bad_next;
    logic        tick, push, frame_hit, parity_hit;

    logic [7:0]  mem [4];
    logic [1:0]  wr_ptr, rd_ptr, rd_next;
    logic [2:0]  count, count_next, kept;
    logic        pop, full, accept, ov_hit;
    logic [7:0]  head_next;

    // The counter reloads to N and samples when it reaches 1, so N cycles separate samples.
    assign tick = (cnt == 16'd1);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1      <= 1'b1;
            rxs        <= 1'b1;
            rxs_prev   <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            par_bad    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync1      <= Rx;
            rxs        <= sync1;
            rxs_prev   <= rxs;
            state      <= state_next;
            cnt        <= cnt_next;
            bit_idx    <= idx_next;
            shift      <= shift_next;
            par_bad    <= par_bad_next;
            frame_err  <= frame_hit;
            parity_err <= parity_hit;
            overrun    <= ov_hit;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        idx_next     = bit_idx;
        shift_next   = shift;
        par_bad_next = par_bad;
        push         = 1'b0;
        frame_hit    = 1'b0;
        parity_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (rxs_prev && !rxs) begin
                    state_next   = START;
                    cnt_next     = HALF;
                    par_bad_next = 1'b0;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_next = cnt - 16'd1;
                end else if (!rxs) begin
                    state_next = DATA;
                    cnt_next   = BIT_LEN;
                    idx_next   = 3'd0;
                end else begin
                    state_next = IDLE;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_next = cnt - 16'd1;
                end else begin
                    shift_next = {rxs, shift[7:1]};
                    cnt_next   = BIT_LEN;
                    if (bit_idx == 3'd7) begin
                        state_next = PARITY_EN ? PARITY : STOP;
                    end else begin
                        idx_next = bit_idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (!tick) begin
                    cnt_next = cnt - 16'd1;
                end else begin
                    par_bad_next = ((^shift) ^ rxs) != PARITY_ODD;
                    state_next   = STOP;
                    cnt_next     = BIT_LEN;
                end
            end
            STOP: begin
                if (!tick) begin
                    cnt_next = cnt - 16'd1;
                end else if (!rxs) begin
                    frame_hit  = 1'b1;
                    state_next = BREAK;
                end else begin
                    parity_hit = par_bad;
                    push       = !par_bad;
                    state_next = IDLE;
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rx_valid  = (count != 3'd0);
    assign pop       = rx_valid && rx_ready;
    assign full      = (count == 3'd4);
    assign accept    = push && (!full || pop);
    assign ov_hit    = push && full && !pop;
    assign rd_next   = pop ? rd_ptr + 2'd1 : rd_ptr;
    assign kept      = count - {2'b00, pop};
    assign count_next = kept + {2'b00, accept};
    // A byte written into an otherwise empty FIFO becomes the head directly.
    assign head_next = (accept && kept == 3'd0) ? shift : mem[rd_next];

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= shift;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rx_data <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            if (count_next != 3'd0) begin
                rx_data <= head_next;
            end
        end
    end

endmodule
